// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit.
// Turns a load/store in MEM into a registered req/ack transaction, stalls the
// pipeline until the access completes, and returns the extended load data.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flags misaligned half/word
// accesses and suppresses their request; when undefined, misalign is tied low).
module dmem_access_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_MEM,
  input  logic              mem_write_MEM,
  input  logic [2:0]        funct3_MEM,
  input  logic [DATA_W-1:0] alu_result_MEM,
  input  logic [DATA_W-1:0] rs2_data_MEM,
  input  logic              Istall,
  input  logic              wfi_stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [3:0]        dm_wstrb,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              Dstall,
  output logic [DATA_W-1:0] Dcache_out_ext,
  output logic              misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_we_q, dm_we_d;
  logic [DATA_W-1:0]   dm_addr_q, dm_addr_d;
  logic [3:0]          dm_wstrb_q, dm_wstrb_d;
  logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          lane_q, lane_d;
  logic                load_q, load_d;

  logic                size_byte;
  logic                size_half;
  logic                misalign_c;
  logic                acc;
  logic [3:0]          wstrb_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [DATA_W-1:0]   ext_c;

  // Decode access size, alignment and the store strobe/data for the MEM instruction
  always_comb begin
    size_byte = (funct3_MEM[1:0] == 2'b00);
    size_half = (funct3_MEM[1:0] == 2'b01);
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign_c = ~rst & (mem_read_MEM | mem_write_MEM) &
                 ((size_half & alu_result_MEM[0]) |
                  (~size_byte & ~size_half & (alu_result_MEM[1:0] != 2'b00)));
`else
    misalign_c = 1'b0;
`endif
    acc = (mem_read_MEM | mem_write_MEM) & ~misalign_c;
    if (size_byte) begin
      wstrb_c = 4'b0001 << alu_result_MEM[1:0];
      wdata_c = {4{rs2_data_MEM[7:0]}};
    end else if (size_half) begin
      wstrb_c = 4'b0011 << {alu_result_MEM[1], 1'b0};
      wdata_c = {2{rs2_data_MEM[15:0]}};
    end else begin
      wstrb_c = 4'b1111;
      wdata_c = rs2_data_MEM;
    end
  end

  // Next-state and register-load logic for the IDLE/REQ/DONE handshake
  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wstrb_d = dm_wstrb_q;
    dm_wdata_d = dm_wdata_q;
    rdata_d    = rdata_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    load_d     = load_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d    = S_REQ;
          dm_req_d   = 1'b1;
          dm_we_d    = mem_write_MEM;
          dm_addr_d  = {alu_result_MEM[DATA_W-1:2], 2'b00};
          dm_wstrb_d = wstrb_c;
          dm_wdata_d = wdata_c;
          funct3_d   = funct3_MEM;
          lane_d     = alu_result_MEM[1:0];
          load_d     = ~mem_write_MEM;
        end
      end
      S_REQ: begin
        if (dm_ack) begin
          if (!dm_we_q) begin
            rdata_d = dm_rdata;
          end
          dm_req_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // The instruction stays in MEM until the rest of the pipeline moves
        if (!Istall && !wfi_stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wstrb_q <= '0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
      funct3_q   <= '0;
      lane_q     <= '0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wstrb_q <= dm_wstrb_d;
      dm_wdata_q <= dm_wdata_d;
      rdata_q    <= rdata_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      load_q     <= load_d;
    end
  end

  // Lane select and sign/zero extension of the captured read word
  always_comb begin
    case (lane_q)
      2'b00:   byte_lane = rdata_q[7:0];
      2'b01:   byte_lane = rdata_q[15:8];
      2'b10:   byte_lane = rdata_q[23:16];
      default: byte_lane = rdata_q[31:24];
    endcase
    half_lane = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'b000:  ext_c = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  ext_c = {{16{half_lane[15]}}, half_lane};
      3'b100:  ext_c = {24'h0, byte_lane};
      3'b101:  ext_c = {16'h0, half_lane};
      default: ext_c = rdata_q;
    endcase
    Dcache_out_ext = ((state_q == S_DONE) && load_q) ? ext_c : '0;
  end

  // Data-side stall: decode cycle of an access plus every cycle waiting for ack
  always_comb begin
    Dstall = ~rst & (((state_q == S_IDLE) & acc) | (state_q == S_REQ));
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wstrb = dm_wstrb_q;
  assign dm_wdata = dm_wdata_q;
  assign misalign = misalign_c;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: a byte-array reference model predicts
// request fields, load results and stall lengths; monitors compare as the DUT
// presents requests and as the pipeline advances.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_MEM, mem_write_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] alu_result_MEM, rs2_data_MEM;
  logic        Istall, wfi_stall;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        Dstall;
  logic [31:0] Dcache_out_ext;
  logic        misalign;

  always #5 clk = ~clk;

  dmem_access_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_read_MEM(mem_read_MEM), .mem_write_MEM(mem_write_MEM),
    .funct3_MEM(funct3_MEM), .alu_result_MEM(alu_result_MEM),
    .rs2_data_MEM(rs2_data_MEM), .Istall(Istall), .wfi_stall(wfi_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .Dstall(Dstall), .Dcache_out_ext(Dcache_out_ext), .misalign(misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] exp_ext;
    logic        exp_mis;
    int unsigned exp_stall;
  } res_t;

  req_t        req_q[$];
  res_t        res_q[$];
  int unsigned dly_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] rmem [64];

  logic        res_en = 1'b0;
  logic        resp_en = 1'b1;
  logic        ack_force = 1'b0;
  logic [31:0] ack_data = 32'h0;

  function automatic logic [31:0] mem_init(input int unsigned i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: random ack latency, spurious acks while no request is open
  initial begin : responder
    logic        waiting;
    int unsigned wait_cnt;
    logic [5:0]  idx;
    dm_ack = 1'b0;
    dm_rdata = '0;
    waiting = 1'b0;
    wait_cnt = 0;
    for (int i = 0; i < 64; i++) rmem[i] = mem_init(i);
    forever begin
      @(posedge clk);
      #1;
      dm_ack = 1'b0;
      if (!resp_en) begin
        waiting  = 1'b0;
        dm_ack   = ack_force;
        dm_rdata = ack_data;
      end else if (dm_req) begin
        if (!waiting) begin
          waiting = 1'b1;
          wait_cnt = 0;
          if (dly_q.size() > 0) wait_cnt = dly_q.pop_front();
        end
        if (wait_cnt == 0) begin
          idx      = dm_addr[7:2];
          dm_rdata = rmem[idx];
          dm_ack   = 1'b1;
          waiting  = 1'b0;
          if (dm_we) begin
            for (int k = 0; k < 4; k++)
              if (dm_wstrb[k]) rmem[idx][8*k +: 8] = dm_wdata[8*k +: 8];
          end
        end else begin
          wait_cnt--;
        end
      end else if ($urandom_range(7) == 0) begin
        dm_ack   = 1'b1;
        dm_rdata = $urandom;
      end
    end
  end

  // Monitor: request fields on every REQ cycle, results when MEM/WB captures
  initial begin : monitor
    logic        req_prev;
    logic        adv;
    int unsigned stall_cnt;
    req_t        cur_req;
    res_t        cur_res;
    req_prev = 1'b0;
    stall_cnt = 0;
    cur_req = '{we: 1'b0, addr: 32'h0, wstrb: 4'h0, wdata: 32'h0};
    forever begin
      @(negedge clk);
      adv = !Dstall && !Istall && !wfi_stall;
      if (dm_req) begin
        if (!req_prev) begin
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: dm_req=1 required 0 at %0t", $time);
          end else begin
            cur_req = req_q.pop_front();
          end
        end
        chk("dm_we", 32'(dm_we), 32'(cur_req.we));
        chk("dm_addr", dm_addr, cur_req.addr);
        if (cur_req.we) begin
          chk("dm_wstrb", 32'(dm_wstrb), 32'(cur_req.wstrb));
          chk("dm_wdata", dm_wdata, cur_req.wdata);
        end
      end
      req_prev = dm_req;
      if (!res_en) begin
        stall_cnt = 0;
      end else if (res_q.size() == 0) begin
        if (adv) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: pipeline advanced with no instruction at %0t", $time);
        end
      end else begin
        cur_res = res_q[0];
        chk("misalign", 32'(misalign), 32'(cur_res.exp_mis));
        if (!Dstall) chk("Dcache_out_ext", Dcache_out_ext, cur_res.exp_ext);
        if (Dstall) stall_cnt++;
        if (adv) begin
          chk("stall_cycles", stall_cnt, cur_res.exp_stall);
          void'(res_q.pop_front());
          stall_cnt = 0;
        end
      end
    end
  end

  // Issue one instruction into MEM and hold it until the pipeline advances
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rs2,
                       input int unsigned d, input int unsigned ist_hold, input bit rnd);
    int unsigned sz, off, cyc;
    logic [31:0] base, val;
    logic [7:0]  bi;
    logic        mis, acc, adv, done;
    req_t        rq;
    res_t        rs;
    sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis  = (rd || wr) && ((a % sz) != 0);
`endif
    acc  = (rd || wr) && !mis;
    base = a - (a % sz);
    off  = base % 4;
    val  = 32'h0;
    for (int i = 0; i < int'(sz); i++) begin
      bi  = 8'(base + 32'(i));
      val = val | (32'(ref_mem[bi]) << (8 * i));
    end
    if (f3[2] == 1'b0 && sz < 4 && val[8*sz-1]) val = val | ~((32'd1 << (8 * sz)) - 1);
    if (wr && acc) begin
      for (int i = 0; i < int'(sz); i++) begin
        bi = 8'(base + 32'(i));
        ref_mem[bi] = rs2[8*i +: 8];
      end
    end
    rs.exp_ext   = (rd && !wr && acc) ? val : 32'h0;
    rs.exp_mis   = mis;
    rs.exp_stall = acc ? 2 + d : 0;
    rq.we    = wr;
    rq.addr  = a - (a % 4);
    rq.wstrb = 4'(((32'd1 << sz) - 1) << off);
    rq.wdata = (sz == 1) ? {4{rs2[7:0]}} : (sz == 2) ? {2{rs2[15:0]}} : rs2;
    mem_read_MEM   = rd;
    mem_write_MEM  = wr;
    funct3_MEM     = f3;
    alu_result_MEM = a;
    rs2_data_MEM   = rs2;
    res_q.push_back(rs);
    if (acc) begin
      req_q.push_back(rq);
      dly_q.push_back(d);
    end
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      Istall    = (cyc < ist_hold) ? 1'b1 : (rnd ? ($urandom_range(3) == 0) : 1'b0);
      wfi_stall = rnd ? ($urandom_range(7) == 0) : 1'b0;
      @(negedge clk);
      adv = !Dstall && !Istall && !wfi_stall;
      @(posedge clk);
      #1;
      cyc++;
      if (adv) begin
        done = 1'b1;
      end else if (cyc > 64) begin
        errors++;
        $display("FAIL timeout: instruction held %0d cycles, required under 65", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "stuck");
      end
    end
  endtask

  initial begin : stimulus
    logic [31:0] w;
    req_t        rq;
    for (int b = 0; b < 256; b++) begin
      w = mem_init(b / 4);
      ref_mem[b] = w[8*(b%4) +: 8];
    end
    rst = 1'b1;
    mem_read_MEM = 1'b1;
    mem_write_MEM = 1'b1;
    funct3_MEM = 3'b010;
    alu_result_MEM = 32'h104;
    rs2_data_MEM = 32'hFFFF_FFFF;
    Istall = 1'b0;
    wfi_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dm_req", 32'(dm_req), 32'h0);
    chk("rst_dm_we", 32'(dm_we), 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wstrb", 32'(dm_wstrb), 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    chk("rst_Dstall", 32'(Dstall), 32'h0);
    chk("rst_Dcache_out_ext", Dcache_out_ext, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    mem_read_MEM = 1'b0;
    mem_write_MEM = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    res_en = 1'b1;

    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h80FF_1234, 0, 0, 1'b0);
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 1'b0);
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hBEEF_0000, 1, 0, 1'b0);
    issue(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 0, 1'b0);
    issue(1'b0, 1'b1, 3'b000, 32'h41, 32'h1234_56AB, 0, 0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 5, 1'b0);
    issue(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 0, 0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 1'b0);
    issue(1'b1, 1'b1, 3'b001, 32'h23, 32'h5555_A5A5, 1, 0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      int unsigned kind;
      kind = $urandom_range(3);
      issue(kind == 1 || kind == 3, kind >= 2, 3'($urandom_range(7)), $urandom,
            $urandom, $urandom_range(4), 0, 1'b1);
    end

    res_en = 1'b0;
    mem_read_MEM = 1'b0;
    mem_write_MEM = 1'b0;
    Istall = 1'b0;
    wfi_stall = 1'b0;
    @(negedge clk);
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    mem_read_MEM = 1'b1;
    funct3_MEM = 3'b010;
    alu_result_MEM = 32'h20;
    rq = '{we: 1'b0, addr: 32'h20, wstrb: 4'h0, wdata: 32'h0};
    req_q.push_back(rq);
    @(negedge clk);
    chk("abort_decode_Dstall", 32'(Dstall), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_req_up", 32'(dm_req), 32'h1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_dm_req", 32'(dm_req), 32'h0);
    chk("abort_Dstall", 32'(Dstall), 32'h0);
    chk("abort_Dcache_out_ext", Dcache_out_ext, 32'h0);
    chk("abort_dm_addr", dm_addr, 32'h0);
    mem_read_MEM = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    ack_data = 32'hDEAD_BEEF;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    chk("late_ack_dm_req", 32'(dm_req), 32'h0);
    chk("late_ack_Dstall", 32'(Dstall), 32'h0);
    chk("late_ack_Dcache_out_ext", Dcache_out_ext, 32'h0);
    resp_en = 1'b1;
    @(posedge clk);
    #1;
    res_en = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1, 0, 1'b0);
    issue(1'b1, 1'b0, 3'b100, 32'h22, 32'h0, 0, 0, 1'b0);
    issue(1'b0, 1'b1, 3'b001, 32'h26, 32'h0000_8001, 0, 0, 1'b0);
    issue(1'b1, 1'b0, 3'b001, 32'h26, 32'h0, 3, 0, 1'b0);
    res_en = 1'b0;
    mem_read_MEM = 1'b0;
    mem_write_MEM = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("req_q_drained", 32'(req_q.size()), 32'h0);
    chk("res_q_drained", 32'(res_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
